// File: rtl/digit_scanner.sv
// Time-multiplexed 4-slot display scanner: steps SEL_OUT through the slots with a
// blanking gap between them and swaps in new frames only at the frame wrap.
module digit_scanner #(
    parameter int unsigned PRESCALE     = 1000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned DATA_W       = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  RUN,
    input  logic [4*DATA_W-1:0]   DATA_IN,
    input  logic                  DATA_VALID,
    output logic                  DATA_READY,
    output logic [1:0]            SEL_OUT,
    output logic [DATA_W-1:0]     DIGIT_OUT,
    output logic                  ENABLE_OUT,
    output logic                  FRAME_DONE
);

    localparam int unsigned CntMax = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] ShowLast  = CntW'(PRESCALE - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StShow, StBlank} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [1:0]            sel_q, sel_d;
    logic [DATA_W-1:0]     digit_q, digit_d;
    logic                  enable_q, enable_d;
    logic                  frame_done_q, frame_done_d;
    logic                  ready_q, ready_d;
    logic [4*DATA_W-1:0]   display_q, display_d;
    logic [4*DATA_W-1:0]   pending_q, pending_d;
    logic                  pend_full_q, pend_full_d;
    logic                  accept;

    assign accept = DATA_VALID & ready_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        enable_d     = 1'b0;
        frame_done_d = 1'b0;
        display_d    = display_q;
        pending_d    = pending_q;
        pend_full_d  = pend_full_q;

        unique case (state_q)
            StIdle: begin
                sel_d = 2'd0;
                cnt_d = '0;
                // Nothing is being scanned, so a new frame goes straight to the display
                // and supersedes anything still parked in pending.
                if (accept) begin
                    display_d   = DATA_IN;
                    pend_full_d = 1'b0;
                end
                if (RUN) begin
                    state_d  = StShow;
                    enable_d = 1'b1;
                end
            end
            StShow: begin
                if (accept) begin
                    pending_d   = DATA_IN;
                    pend_full_d = 1'b1;
                end
                if (cnt_q == ShowLast) begin
                    state_d = StBlank;
                    cnt_d   = '0;
                    sel_d   = sel_q + 2'd1;
                    if (sel_q == 2'd3) begin
                        frame_done_d = 1'b1;
                        // Ready is low while pending is full, so this never races accept.
                        if (pend_full_q) begin
                            display_d   = pending_q;
                            pend_full_d = 1'b0;
                        end
                    end
                end else begin
                    cnt_d    = cnt_q + CntW'(1);
                    enable_d = 1'b1;
                end
            end
            StBlank: begin
                if (accept) begin
                    pending_d   = DATA_IN;
                    pend_full_d = 1'b1;
                end
                if (cnt_q == BlankLast) begin
                    cnt_d = '0;
                    if (RUN) begin
                        state_d  = StShow;
                        enable_d = 1'b1;
                    end else begin
                        state_d = StIdle;
                        sel_d   = 2'd0;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        ready_d = (state_d == StIdle) ? 1'b1 : ~pend_full_d;
        digit_d = display_d[sel_d*DATA_W +: DATA_W];
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            sel_q        <= 2'd0;
            digit_q      <= '0;
            enable_q     <= 1'b0;
            frame_done_q <= 1'b0;
            ready_q      <= 1'b0;
            display_q    <= '0;
            pending_q    <= '0;
            pend_full_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            digit_q      <= digit_d;
            enable_q     <= enable_d;
            frame_done_q <= frame_done_d;
            ready_q      <= ready_d;
            display_q    <= display_d;
            pending_q    <= pending_d;
            pend_full_q  <= pend_full_d;
        end
    end

    assign DATA_READY = ready_q;
    assign SEL_OUT    = sel_q;
    assign DIGIT_OUT  = digit_q;
    assign ENABLE_OUT = enable_q;
    assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_digit_scanner.sv
// Bench for digit_scanner: expected slot/frame-done events are queued from a
// time-based frame model and checked by an independent monitor.
module tb_digit_scanner;

    localparam int PRE   = 4;
    localparam int BLK   = 2;
    localparam int SLOT  = PRE + BLK;
    localparam int FRAME = 4 * SLOT;
    localparam int NF    = 5;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        RUN;
    logic [15:0] DATA_IN;
    logic        DATA_VALID;
    logic        DATA_READY;
    logic [1:0]  SEL_OUT;
    logic [3:0]  DIGIT_OUT;
    logic        ENABLE_OUT;
    logic        FRAME_DONE;

    digit_scanner #(
        .PRESCALE     (PRE),
        .BLANK_CYCLES (BLK),
        .DATA_W       (4)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .RUN        (RUN),
        .DATA_IN    (DATA_IN),
        .DATA_VALID (DATA_VALID),
        .DATA_READY (DATA_READY),
        .SEL_OUT    (SEL_OUT),
        .DIGIT_OUT  (DIGIT_OUT),
        .ENABLE_OUT (ENABLE_OUT),
        .FRAME_DONE (FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        int         edge_n;
        logic [1:0] sel;
        logic [3:0] digit;
    } slot_t;

    slot_t exp_q[$];
    int    fd_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame model: slot s of a frame starting at edge st rises at st + s*SLOT.
    task automatic push_frame(input int st, input logic [15:0] d, input int nslots,
                              input bit fd);
        for (int s = 0; s < nslots; s++) begin
            slot_t x;
            x.edge_n = st + s * SLOT;
            x.sel    = 2'(s);
            x.digit  = d[s*4 +: 4];
            exp_q.push_back(x);
        end
        if (fd) fd_q.push_back(st + FRAME - BLK);
    endtask

    task automatic at_edge(input int e);
        while (cyc < e) @(negedge CLK);
    endtask

    task automatic send(input logic [15:0] d, output int acc);
        acc        = -1;
        DATA_IN    = d;
        DATA_VALID = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (DATA_READY === 1'b1) begin
                @(negedge CLK);
                acc = cyc;
                break;
            end
            @(negedge CLK);
        end
        DATA_VALID = 1'b0;
        if (acc < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: data %0h not accepted, required within 100 cycles", d);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sel"},    32'(SEL_OUT),    0);
        chk({tag, "_digit"},  32'(DIGIT_OUT),  0);
        chk({tag, "_enable"}, 32'(ENABLE_OUT), 0);
        chk({tag, "_fdone"},  32'(FRAME_DONE), 0);
        chk({tag, "_ready"},  32'(DATA_READY), 0);
    endtask

    // Monitor
    logic       prev_en  = 1'b0;
    logic [1:0] prev_sel = 2'd0;
    int         rise_at  = 0;
    slot_t      cur;
    slot_t      e_slot;
    int         e_fd;

    always @(negedge CLK) begin
        if (cyc > 0) begin
            if (ENABLE_OUT === 1'b1 && prev_en !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_slot: slot %0d shown at edge %0d, none required",
                             SEL_OUT, cyc);
                end else begin
                    e_slot = exp_q.pop_front();
                    cur = e_slot;
                    chk("slot_edge", cyc, e_slot.edge_n);
                end
                rise_at = cyc;
            end
            if (ENABLE_OUT === 1'b1) begin
                chk("slot_sel", 32'(SEL_OUT), 32'(cur.sel));
                chk("slot_digit", 32'(DIGIT_OUT), 32'(cur.digit));
            end
            if (ENABLE_OUT !== 1'b1 && prev_en === 1'b1) chk("show_len", cyc - rise_at, PRE);
            if (FRAME_DONE === 1'b1) begin
                if (fd_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_frame_done: pulse at edge %0d, none required", cyc);
                end else begin
                    e_fd = fd_q.pop_front();
                    chk("frame_done_edge", cyc, e_fd);
                end
            end
            if (SEL_OUT !== prev_sel) chk("sel_change_while_enabled", 32'(ENABLE_OUT), 0);
            prev_en  = ENABLE_OUT;
            prev_sel = SEL_OUT;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, required finish before 100000");
        $fatal(1);
    end

    initial begin
        int          acc, k, k2, k3, base, s0, off;
        logic [15:0] d;

        RST_N      = 1'b0;
        RUN        = 1'b1;
        DATA_VALID = 1'b0;
        DATA_IN    = '0;

        repeat (3) begin
            @(negedge CLK);
            chk_all_zero("reset");
        end
        RST_N = 1'b1;
        RUN   = 1'b0;
        @(negedge CLK);
        chk("ready_after_reset", 32'(DATA_READY), 1);
        chk("sel_after_reset", 32'(SEL_OUT), 0);
        chk("enable_after_reset", 32'(ENABLE_OUT), 0);

        // Idle load writes the display directly.
        send(16'h4321, acc);
        chk("idle_ready_held", 32'(DATA_READY), 1);
        chk("idle_digit", 32'(DIGIT_OUT), 1);
        RUN = 1'b1;
        k = cyc + 1;
        push_frame(k, 16'h4321, 4, 1'b1);

        // One new frame per frame period, presented at a random point.
        for (int f = 1; f <= NF; f++) begin
            d   = (f == 1) ? 16'h8765 : 16'($urandom);
            off = (f == 1) ? 8 : int'($urandom_range(18, 0));
            at_edge(k + FRAME * (f - 1) + off);
            send(d, acc);
            push_frame(k + FRAME * f, d, 4, 1'b1);
            if (f == 1) begin
                chk("accept_one_cycle", acc, k + 9);
                chk("ready_low_after_accept", 32'(DATA_READY), 0);
                at_edge(k + FRAME - BLK - 1);
                chk("ready_low_before_wrap", 32'(DATA_READY), 0);
                at_edge(k + FRAME - BLK);
                chk("ready_after_commit", 32'(DATA_READY), 1);
                chk("digit_after_commit", 32'(DIGIT_OUT), 5);
            end
        end

        // Backpressure: second frame must wait for the commit.
        base = k + FRAME * NF;
        at_edge(base + 2);
        d = 16'($urandom);
        send(d, acc);
        push_frame(base + FRAME, d, 4, 1'b1);
        chk("ready_low_pending_full", 32'(DATA_READY), 0);
        send(16'hAAAA, acc);
        chk("bp_accept_after_commit", acc, base + FRAME - BLK + 1);

        // Stop in the middle of slot 2.
        s0 = base + 2 * FRAME;
        push_frame(s0, 16'hAAAA, 3, 1'b0);
        at_edge(s0 + 2 * SLOT + 2);
        RUN = 1'b0;
        at_edge(s0 + 2 * SLOT + PRE + 1);
        chk("stop_blank_enable", 32'(ENABLE_OUT), 0);
        chk("stop_blank_sel", 32'(SEL_OUT), 3);
        at_edge(s0 + 3 * SLOT);
        chk("stop_idle_sel", 32'(SEL_OUT), 0);
        chk("stop_idle_enable", 32'(ENABLE_OUT), 0);
        at_edge(s0 + 3 * SLOT + 2);
        chk("idle_enable_held", 32'(ENABLE_OUT), 0);
        RUN = 1'b1;
        k2 = cyc + 1;
        push_frame(k2, 16'hAAAA, 1, 1'b0);

        // Reset during blank with a pending frame.
        at_edge(k2 + 1);
        d = 16'($urandom) | 16'h0001;
        send(d, acc);
        at_edge(k2 + PRE);
        chk("pending_full_in_blank", 32'(DATA_READY), 0);
        chk("blank_enable", 32'(ENABLE_OUT), 0);
        RST_N = 1'b0;
        @(negedge CLK);
        chk_all_zero("midscan_reset");
        RST_N = 1'b1;
        k3 = cyc + 1;
        push_frame(k3, 16'h0000, 4, 1'b1);
        push_frame(k3 + FRAME, 16'h0000, 1, 1'b0);
        @(negedge CLK);
        chk("ready_after_midscan_reset", 32'(DATA_READY), 1);
        at_edge(k3 + FRAME + 1);
        RUN = 1'b0;
        at_edge(k3 + FRAME + SLOT + 4);
        chk("final_sel", 32'(SEL_OUT), 0);
        chk("final_enable", 32'(ENABLE_OUT), 0);
        chk("slots_outstanding", exp_q.size(), 0);
        chk("frame_done_outstanding", fd_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/digit_scanner.md
Name: digit_scanner

Overview:
- Time-multiplexed scan controller for the 4-digit/4-column board display.
- Holds one 4-slot frame of display data and steps a 2-bit select, SEL_OUT, through 0..3. SEL_OUT feeds the one-hot 4-output decoder directly downstream.
- Drives per-slot data and a drive enable, with a blanking gap between slots to prevent ghosting.
- Takes new frames over a valid/ready handshake and swaps them in only at frame boundaries, so the display never tears.

Parameters:
- PRESCALE, 1000: CLK cycles each slot is driven (ENABLE_OUT high). Legal range ≥1.
- BLANK_CYCLES, 16: CLK cycles of blanking after each slot. Legal range ≥1.
- DATA_W, 4: bits per slot.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  synchronous reset, active-low.
- RUN  in  1  scan enable.
- DATA_IN  in  4*DATA_W  new frame. Slot n = DATA_IN[n*DATA_W +: DATA_W].
- DATA_VALID  in  1  DATA_IN is valid.
- DATA_READY  out  1  block can accept a frame.
- SEL_OUT  out  2  current slot index, to the decoder's VAL_IN.
- DIGIT_OUT  out  DATA_W  data for the current slot.
- ENABLE_OUT  out  1  drive enable; low during IDLE and BLANK.
- FRAME_DONE  out  1  one-cycle pulse at each frame wrap.

Behaviour:
- **Reset** (RST_N low at an edge):
  - State = IDLE.
  - SEL_OUT=0, DIGIT_OUT=0, ENABLE_OUT=0, FRAME_DONE=0, DATA_READY=0.
  - Display register = 0, pending register empty, all counters = 0.
  - Reset has priority over every other event, including mid-SHOW/BLANK; the frame is abandoned.
  - DATA_READY goes high the first cycle after RST_N returns high.
- **Registered outputs:** all outputs are registered. DIGIT_OUT always equals display[SEL_OUT] as of the same edge that updates SEL_OUT.
- **States:** IDLE, SHOW, BLANK. There is a cycle counter cnt.
- **IDLE:**
  - ENABLE_OUT=0, SEL_OUT=0.
  - A handshake (DATA_VALID & DATA_READY) writes DATA_IN straight into the display register. DATA_READY stays high.
  - RUN high at edge k: SHOW from cycle k+1 with cnt=0 and ENABLE_OUT=1.
- **SHOW:**
  - ENABLE_OUT=1 for exactly PRESCALE cycles.
  - At the edge ending the PRESCALE-th cycle, enter BLANK. On that same edge: ENABLE_OUT←0, SEL_OUT←SEL_OUT+1 (mod 4, 3 wraps to 0), DIGIT_OUT←data for the new slot.
  - The decoder therefore switches only while the drive is disabled.
- **BLANK:**
  - ENABLE_OUT=0 for exactly BLANK_CYCLES cycles.
  - At the end: if RUN=1, go to SHOW (ENABLE_OUT←1). If RUN=0, go to IDLE and force SEL_OUT←0.
  - RUN is sampled only at the end of BLANK and in IDLE. Dropping RUN mid-SHOW completes the slot and its blank.
- **Frame wrap** (the SHOW→BLANK edge where SEL_OUT goes 3→0):
  - FRAME_DONE=1 for the one following cycle.
  - If pending is full, pending→display on that same edge. DIGIT_OUT then shows new slot 0, and pending is emptied.
- **Handshake outside IDLE:**
  - DATA_READY = pending empty.
  - A handshake loads pending, and DATA_READY drops on the next cycle.
  - DATA_VALID without DATA_READY is ignored. The source must hold its data.
  - In the commit cycle pending is full, so commit and accept cannot coincide. DATA_READY is high again from the cycle after the commit.
- **Frame period:** 4*(PRESCALE+BLANK_CYCLES) cycles.
- **Other rules:**
  - Counters saturate only through their state transitions; no overflow beyond the parameter range.
  - No X on any output after reset.

Test Plan (PRESCALE=4, BLANK_CYCLES=2, DATA_W=4):
- **Reset values:** RST_N low 3 cycles, RUN=1 → all outputs 0 during reset; DATA_READY=1 the cycle after release; SEL_OUT=0.
- **Scan sequence:** in IDLE, load DATA_IN=16'h4321, then RUN=1 →
  - ENABLE_OUT pattern is 4 high, 2 low, repeating.
  - SEL_OUT runs 0,1,2,3,0 and changes only on the edges where ENABLE_OUT falls.
  - DIGIT_OUT runs 1,2,3,4.
  - FRAME_DONE pulses every 24 cycles.
- **Tear-free update:** while running, mid-slot 1 present 16'h8765 with VALID →
  - Accepted in one cycle; DATA_READY low until the wrap.
  - Slots 2 and 3 still show 3 and 4; after the wrap DIGIT_OUT shows 5 and FRAME_DONE=1 in that cycle.
  - DATA_READY high the next cycle.
- **Backpressure:** hold VALID with 16'hAAAA while pending is full → no load. DATA_READY returns after the commit, then AAAA loads, and the display changes one full frame later.
- **Stop mid-slot:** drop RUN mid-slot 2 → slot 2 completes its 4 cycles and 2-cycle blank, then IDLE with SEL_OUT=0 and ENABLE_OUT=0. Re-asserting RUN restarts at slot 0.
- **Reset mid-scan:** assert RST_N low during BLANK with pending full → next cycle all outputs 0, pending discarded, and the display register reads 0 after restart.
